// File: rtl/reg_dump_scanner_if.sv
// Bus between the register-dump scanner and its environment: control inputs,
// the CPU debug read port (reg_sel -> reg_data) and the {index, data} record stream.
interface reg_dump_scanner_if #(
    parameter int unsigned IDX_W  = 5,
    parameter int unsigned DATA_W = 32
);
    logic              start;
    logic              abort;
    logic [IDX_W-1:0]  reg_sel;
    logic [DATA_W-1:0] reg_data;
    logic              out_valid;
    logic              out_ready;
    logic [IDX_W-1:0]  out_idx;
    logic [DATA_W-1:0] out_data;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] signature;

    // Scanner side
    modport master (
        input  start, abort, reg_data, out_ready,
        output reg_sel, out_valid, out_idx, out_data, busy, done, signature
    );

    // Environment side: CPU debug port, controller and record consumer
    modport slave (
        output start, abort, reg_data, out_ready,
        input  reg_sel, out_valid, out_idx, out_data, busy, done, signature
    );
endinterface

// File: rtl/reg_dump_scanner.sv
// Walks the CPU debug register-read port over the whole register file and emits
// one {index, data} record per register on a valid/ready stream, while folding
// every emitted word into an XOR signature.
module reg_dump_scanner #(
    parameter int unsigned NUM_REGS  = 32,
    parameter int unsigned IDX_W     = 5,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned SETTLE    = 1,
    parameter bit          SKIP_ZERO = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    reg_dump_scanner_if.master bus
);

    localparam int unsigned     CNT_W      = $clog2(SETTLE + 1);
    localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(SKIP_ZERO);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REGS - 1);
    localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(SETTLE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_WAIT,
        S_SEND,
        S_FIN
    } state_t;

    state_t            state_q,     state_n;
    logic [IDX_W-1:0]  idx_q,       idx_n;
    logic [CNT_W-1:0]  cnt_q,       cnt_n;
    logic [IDX_W-1:0]  reg_sel_q,   reg_sel_n;
    logic              out_valid_q, out_valid_n;
    logic [IDX_W-1:0]  out_idx_q,   out_idx_n;
    logic [DATA_W-1:0] out_data_q,  out_data_n;
    logic              busy_q,      busy_n;
    logic              done_q,      done_n;
    logic [DATA_W-1:0] sig_q,       sig_n;

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            reg_sel_q   <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sig_q       <= '0;
        end else begin
            state_q     <= state_n;
            idx_q       <= idx_n;
            cnt_q       <= cnt_n;
            reg_sel_q   <= reg_sel_n;
            out_valid_q <= out_valid_n;
            out_idx_q   <= out_idx_n;
            out_data_q  <= out_data_n;
            busy_q      <= busy_n;
            done_q      <= done_n;
            sig_q       <= sig_n;
        end
    end

    // Next-state and next-output logic; abort overrides everything outside IDLE
    always_comb begin
        state_n     = state_q;
        idx_n       = idx_q;
        cnt_n       = cnt_q;
        reg_sel_n   = reg_sel_q;
        out_valid_n = out_valid_q;
        out_idx_n   = out_idx_q;
        out_data_n  = out_data_q;
        busy_n      = busy_q;
        done_n      = 1'b0;
        sig_n       = sig_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_n = S_SEL;
                    idx_n   = FIRST_IDX;
                    sig_n   = '0;
                    busy_n  = 1'b1;
                end
            end
            S_SEL: begin
                reg_sel_n = idx_q;
                cnt_n     = SETTLE_CNT;
                state_n   = S_WAIT;
            end
            S_WAIT: begin
                cnt_n = cnt_q - CNT_W'(1);
                if (cnt_n == '0) begin
                    out_data_n  = bus.reg_data;
                    out_idx_n   = idx_q;
                    sig_n       = sig_q ^ bus.reg_data;
                    out_valid_n = 1'b1;
                    state_n     = S_SEND;
                end
            end
            S_SEND: begin
                if (bus.out_ready) begin
                    out_valid_n = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        state_n = S_FIN;
                    end else begin
                        idx_n   = idx_q + IDX_W'(1);
                        state_n = S_SEL;
                    end
                end
            end
            S_FIN: begin
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // Abort keeps only what was already emitted (signature, last record)
        if (bus.abort && (state_q != S_IDLE)) begin
            state_n     = S_IDLE;
            idx_n       = idx_q;
            out_valid_n = 1'b0;
            out_idx_n   = out_idx_q;
            out_data_n  = out_data_q;
            busy_n      = 1'b0;
            done_n      = 1'b0;
            sig_n       = sig_q;
        end
    end

    assign bus.reg_sel   = reg_sel_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.signature = sig_q;

endmodule

// File: tb/tb_reg_dump_scanner.sv
// Bench for reg_dump_scanner: unit 0 uses the default configuration, unit 1 skips
// r0 with a 3-cycle settle time. A stream model checks every record and done pulse.
module tb_reg_dump_scanner;

    localparam logic [31:0] NOISE = 32'hA5A5_5A5A;

    logic clk;
    logic rst;

    reg_dump_scanner_if #(.IDX_W(5), .DATA_W(32)) bus_a ();
    reg_dump_scanner_if #(.IDX_W(5), .DATA_W(32)) bus_b ();

    reg_dump_scanner dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    reg_dump_scanner #(
        .NUM_REGS  (32),
        .IDX_W     (5),
        .DATA_W    (32),
        .SETTLE    (3),
        .SKIP_ZERO (1'b1)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    // Register file contents; the port output is scrambled while a record is held,
    // which must never leak into an already sampled record.
    logic [31:0] regs [32];
    assign bus_a.reg_data = regs[bus_a.reg_sel] ^ (bus_a.out_valid ? NOISE : 32'h0);
    assign bus_b.reg_data = regs[bus_b.reg_sel] ^ (bus_b.out_valid ? NOISE : 32'h0);

    logic [1:0] st, ab, rdy;
    assign bus_a.start     = st[0];
    assign bus_b.start     = st[1];
    assign bus_a.abort     = ab[0];
    assign bus_b.abort     = ab[1];
    assign bus_a.out_ready = rdy[0];
    assign bus_b.out_ready = rdy[1];

    logic [1:0]  vld, bsy, dn;
    logic [4:0]  oidx [2];
    logic [31:0] odat [2];
    logic [31:0] osig [2];
    logic [4:0]  rsel [2];
    assign vld[0] = bus_a.out_valid;  assign vld[1] = bus_b.out_valid;
    assign bsy[0] = bus_a.busy;       assign bsy[1] = bus_b.busy;
    assign dn[0]  = bus_a.done;       assign dn[1]  = bus_b.done;
    assign oidx[0] = bus_a.out_idx;   assign oidx[1] = bus_b.out_idx;
    assign odat[0] = bus_a.out_data;  assign odat[1] = bus_b.out_data;
    assign osig[0] = bus_a.signature; assign osig[1] = bus_b.signature;
    assign rsel[0] = bus_a.reg_sel;   assign rsel[1] = bus_b.reg_sel;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Register contents rule: rN = N * 0x11111111 mod 2^32
    function automatic logic [31:0] word(input int n);
        logic [31:0] nn;
        nn = 32'(n);
        return nn * 32'h1111_1111;
    endfunction

    function automatic logic [31:0] xor_range(input int lo, input int hi);
        logic [31:0] s;
        s = 32'h0;
        for (int i = lo; i <= hi; i++) s = s ^ word(i);
        return s;
    endfunction

    // Stream model: next expected index, expected signature, record/done counts
    int          first_idx [2] = '{0, 1};
    int          nexp  [2] = '{0, 0};
    logic [31:0] msig  [2] = '{32'h0, 32'h0};
    int          nrec  [2] = '{0, 0};
    int          ndone [2] = '{0, 0};
    bit          pstall [2] = '{1'b0, 1'b0};
    logic [4:0]  pidx  [2];
    logic [31:0] pdat  [2];

    // Compare process: every record in order with the right data, held while
    // stalled, and every done pulse closing a complete dump
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (!rst && st[u] && !bsy[u]) begin
                nexp[u] = first_idx[u];
                msig[u] = 32'h0;
                nrec[u] = 0;
            end
            if (vld[u]) begin
                chk($sformatf("u%0d_out_idx", u), 32'(oidx[u]), 32'(nexp[u]));
                chk($sformatf("u%0d_out_data", u), odat[u], word(nexp[u]));
                if (pstall[u]) begin
                    chk($sformatf("u%0d_stall_idx", u), 32'(oidx[u]), 32'(pidx[u]));
                    chk($sformatf("u%0d_stall_data", u), odat[u], pdat[u]);
                end
                if (rdy[u]) begin
                    msig[u] = msig[u] ^ word(nexp[u]);
                    nexp[u]++;
                    nrec[u]++;
                end
            end
            if (dn[u]) begin
                ndone[u]++;
                chk($sformatf("u%0d_done_all_records", u), 32'(nexp[u]), 32'd32);
                chk($sformatf("u%0d_done_signature", u), osig[u], msig[u]);
            end
            pstall[u] = vld[u] && !rdy[u];
            pidx[u]   = oidx[u];
            pdat[u]   = odat[u];
        end
    end

    // One scan on unit u; cycles counts clock edges from the start edge to done
    task automatic run_scan(input int u, input int rdy_pct, input int restart_at,
                            input int abort_at, input int budget,
                            output int cycles, output bit aborted);
        bit hit_r, hit_a;
        hit_r = 1'b0; hit_a = 1'b0; aborted = 1'b0; cycles = 0;
        @(posedge clk); #1;
        st[u] = 1'b1;
        rdy[u] = (rdy_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < rdy_pct);
        @(posedge clk); #1;
        st[u] = 1'b0;
        chk($sformatf("u%0d_busy_after_start", u), 32'(bsy[u]), 32'd1);
        while (1) begin
            if (dn[u] || aborted) break;
            if (cycles >= budget) begin
                total++; bad++;
                $display("FAIL u%0d_scan_timeout: got no done after %0d cycles", u, cycles);
                break;
            end
            rdy[u] = (rdy_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < rdy_pct);
            if (!hit_r && restart_at >= 0 && vld[u] && 32'(oidx[u]) == 32'(restart_at)) begin
                st[u] = 1'b1;
                hit_r = 1'b1;
            end
            if (!hit_a && abort_at >= 0 && vld[u] && 32'(oidx[u]) == 32'(abort_at)) begin
                rdy[u] = 1'b1;
                ab[u]  = 1'b1;
                hit_a  = 1'b1;
            end
            @(posedge clk); cycles++; #1;
            st[u] = 1'b0;
            if (ab[u]) begin
                ab[u]   = 1'b0;
                aborted = 1'b1;
            end
        end
    endtask

    int cyc;
    bit abt;
    int dsnap;

    initial begin
        st = '0; ab = '0; rdy = '0;
        rst = 1'b1;
        for (int i = 0; i < 32; i++) regs[i] = word(i);

        // Model pins against hand-computed values
        chk("pin_r5",  word(5),  32'h5555_5555);
        chk("pin_r16", word(16), 32'h1111_1110);
        chk("pin_r31", word(31), 32'h1111_110F);
        chk("pin_sig_0_5",  xor_range(0, 5),  32'h1111_1111);
        chk("pin_sig_0_31", xor_range(0, 31), 32'h1111_1100);

        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("u%0d_rst_valid", u), 32'(vld[u]), 32'd0);
            chk($sformatf("u%0d_rst_busy", u), 32'(bsy[u]), 32'd0);
            chk($sformatf("u%0d_rst_done", u), 32'(dn[u]), 32'd0);
            chk($sformatf("u%0d_rst_sig", u), osig[u], 32'h0);
            chk($sformatf("u%0d_rst_sel", u), 32'(rsel[u]), 32'd0);
            chk($sformatf("u%0d_rst_idx", u), 32'(oidx[u]), 32'd0);
            chk($sformatf("u%0d_rst_data", u), odat[u], 32'h0);
        end
        rst = 1'b0;

        // Abort while idle does nothing
        @(posedge clk); #1; ab[0] = 1'b1;
        @(posedge clk); #1; ab[0] = 1'b0;
        chk("idle_abort_busy", 32'(bsy[0]), 32'd0);
        chk("idle_abort_valid", 32'(vld[0]), 32'd0);

        // T1: asynchronous reset while record 7 is held
        dsnap = ndone[0];
        @(posedge clk); #1; st[0] = 1'b1; rdy[0] = 1'b1;
        @(posedge clk); #1; st[0] = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (vld[0] && oidx[0] == 5'd7) break;
            @(posedge clk); #1;
        end
        chk("t1_reached_idx7", 32'(oidx[0]), 32'd7);
        rdy[0] = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("t1_async_valid", 32'(vld[0]), 32'd0);
        chk("t1_async_busy", 32'(bsy[0]), 32'd0);
        chk("t1_async_sig", osig[0], 32'h0);
        chk("t1_async_idx", 32'(oidx[0]), 32'd0);
        chk("t1_async_data", odat[0], 32'h0);
        chk("t1_async_sel", 32'(rsel[0]), 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("t1_no_done", 32'(ndone[0]), 32'(dsnap));
        chk("t1_stays_idle", 32'(bsy[0]), 32'd0);

        // T2: full dump, consumer always ready
        dsnap = ndone[0];
        run_scan(0, 100, -1, -1, 300, cyc, abt);
        chk("t2_cycles", 32'(cyc), 32'd97);
        chk("t2_records", 32'(nrec[0]), 32'd32);
        chk("t2_signature", osig[0], 32'h1111_1100);
        chk("t2_busy_low", 32'(bsy[0]), 32'd0);
        @(posedge clk); #1;
        chk("t2_done_one_cycle", 32'(dn[0]), 32'd0);
        chk("t2_done_count", 32'(ndone[0]), 32'(dsnap + 1));
        chk("t2_sel_holds", 32'(rsel[0]), 32'd31);
        repeat (3) @(posedge clk);
        #1;
        chk("t2_sig_stable", osig[0], 32'h1111_1100);

        // T3: consumer ready about 30% of cycles
        dsnap = ndone[0];
        run_scan(0, 30, -1, -1, 3000, cyc, abt);
        chk("t3_records", 32'(nrec[0]), 32'd32);
        chk("t3_signature", osig[0], 32'h1111_1100);
        @(posedge clk); #1;
        chk("t3_done_count", 32'(ndone[0]), 32'(dsnap + 1));

        // T4: start pulsed during record 10 is ignored
        dsnap = ndone[0];
        run_scan(0, 100, 10, -1, 300, cyc, abt);
        chk("t4_cycles", 32'(cyc), 32'd97);
        chk("t4_records", 32'(nrec[0]), 32'd32);
        repeat (110) @(posedge clk);
        #1;
        chk("t4_one_done", 32'(ndone[0]), 32'(dsnap + 1));
        chk("t4_idle", 32'(bsy[0]), 32'd0);

        // T5: abort together with the handshake of record 5
        dsnap = ndone[0];
        run_scan(0, 100, -1, 5, 300, cyc, abt);
        chk("t5_aborted", 32'(abt), 32'd1);
        chk("t5_busy_low", 32'(bsy[0]), 32'd0);
        chk("t5_valid_low", 32'(vld[0]), 32'd0);
        chk("t5_records", 32'(nrec[0]), 32'd6);
        chk("t5_signature", osig[0], 32'h1111_1111);
        chk("t5_signature_model", osig[0], msig[0]);
        chk("t5_sel_holds", 32'(rsel[0]), 32'd5);
        repeat (20) @(posedge clk);
        #1;
        chk("t5_no_done", 32'(ndone[0]), 32'(dsnap));
        chk("t5_no_more_valid", 32'(vld[0]), 32'd0);

        // T6: skip r0, 3-cycle settle: 31 records at 5 cycles each
        dsnap = ndone[1];
        run_scan(1, 100, -1, -1, 400, cyc, abt);
        chk("t6_cycles", 32'(cyc), 32'd156);
        chk("t6_records", 32'(nrec[1]), 32'd31);
        chk("t6_signature", osig[1], 32'h1111_1100);
        @(posedge clk); #1;
        chk("t6_done_count", 32'(ndone[1]), 32'(dsnap + 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
